// File: rtl/aes_sbox_pkg.sv
// Shared types and constants for the S-box arbiter slice.
//   owner_e     : which requester owns the operation in flight
//   arb_state_e : arbiter FSM states
//   STATE_W     : width of the full cipher state and of the shared lookup
//   SBOX_LAT    : lookup latency of sub_b in cycles (one LOOKUP state)
package aes_sbox_pkg;

  localparam int STATE_W  = 128;
  localparam int SBOX_LAT = 1;

  typedef enum logic {
    OWN_CIPHER = 1'b0,
    OWN_KEY    = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sub_b.sv
// Combinational 128-bit AES SubBytes: every byte of in_data is replaced by
// its forward S-box value.
//   in_data  : 128-bit operand
//   out_data : 128-bit substituted result
module sub_b
  import aes_sbox_pkg::*;
(
  input  logic [STATE_W-1:0] in_data,
  output logic [STATE_W-1:0] out_data
);

  // Entry 0x00 sits in the top byte, so entry b lives at bit (255-b)*8,
  // and 255-b is simply ~b for an 8-bit index.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_comb begin
    out_data = '0;
    for (int i = 0; i < STATE_W / 8; i++) begin
      out_data[i*8 +: 8] = SBOX_TABLE[{~in_data[i*8 +: 8], 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/sbox_arbiter.sv
// Shares one sub_b SubBytes instance between the cipher round engine
// (128-bit state) and the key-expansion engine (WORD_W-bit SubWord).
// One operation is outstanding at a time: IDLE grants, LOOKUP captures the
// substituted operand, RESP holds the result until the owner consumes it.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   c_req_valid/ready/data           : cipher request channel
//   c_rsp_valid/ready/data           : cipher response channel
//   k_req_valid/ready/data           : key-word request channel
//   k_rsp_valid/ready/data           : key-word response channel
//   busy                             : FSM is not in IDLE
// Optional macro SBOX_ARB_STATS_EN adds c_grant_cnt, k_grant_cnt (wrapping
// grant counters) and c_wait_max (longest cipher wait, saturating at 0xFF).
module sbox_arbiter
  import aes_sbox_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int WORD_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               c_req_valid,
  output logic               c_req_ready,
  input  logic [STATE_W-1:0] c_req_data,
  output logic               c_rsp_valid,
  input  logic               c_rsp_ready,
  output logic [STATE_W-1:0] c_rsp_data,
  input  logic               k_req_valid,
  output logic               k_req_ready,
  input  logic [WORD_W-1:0]  k_req_data,
  output logic               k_rsp_valid,
  input  logic               k_rsp_ready,
  output logic [WORD_W-1:0]  k_rsp_data,
  output logic               busy
`ifdef SBOX_ARB_STATS_EN
  ,
  output logic [15:0]        c_grant_cnt,
  output logic [15:0]        k_grant_cnt,
  output logic [7:0]         c_wait_max
`endif
);

  arb_state_e         state_q, state_d;
  owner_e             last_grant_q, last_grant_d;
  owner_e             owner_q, owner_d;
  logic [STATE_W-1:0] op_q, op_d;
  logic [STATE_W-1:0] res_q, res_d;
  logic               c_rsp_valid_q, c_rsp_valid_d;
  logic               k_rsp_valid_q, k_rsp_valid_d;
  logic [STATE_W-1:0] sbox_out;
  logic               c_grant, k_grant;

  sub_b u_sub_b (
    .in_data  (op_q),
    .out_data (sbox_out)
  );

  // A tie goes to whoever was not served last, unless the cipher is pinned
  // to the top priority.
  always_comb begin
    c_grant = 1'b0;
    k_grant = 1'b0;
    if (state_q == IDLE) begin
      if (c_req_valid && k_req_valid) begin
        if (FIXED_PRIO != 0 || last_grant_q == OWN_KEY) c_grant = 1'b1;
        else                                            k_grant = 1'b1;
      end else begin
        c_grant = c_req_valid;
        k_grant = k_req_valid;
      end
    end
  end

  // Response valid is registered, so it rises one cycle after RESP is entered
  // and the response ports are driven straight from flops.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    op_d          = op_q;
    res_d         = res_q;
    c_rsp_valid_d = c_rsp_valid_q;
    k_rsp_valid_d = k_rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (c_grant) begin
          op_d         = c_req_data;
          owner_d      = OWN_CIPHER;
          last_grant_d = OWN_CIPHER;
          state_d      = LOOKUP;
        end else if (k_grant) begin
          op_d         = STATE_W'(k_req_data);
          owner_d      = OWN_KEY;
          last_grant_d = OWN_KEY;
          state_d      = LOOKUP;
        end
      end
      LOOKUP: begin
        res_d   = sbox_out;
        state_d = RESP;
      end
      RESP: begin
        if (owner_q == OWN_CIPHER) begin
          if (!c_rsp_valid_q) begin
            c_rsp_valid_d = 1'b1;
          end else if (c_rsp_ready) begin
            c_rsp_valid_d = 1'b0;
            state_d       = IDLE;
          end
        end else begin
          if (!k_rsp_valid_q) begin
            k_rsp_valid_d = 1'b1;
          end else if (k_rsp_ready) begin
            k_rsp_valid_d = 1'b0;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= OWN_KEY;
      owner_q       <= OWN_CIPHER;
      op_q          <= '0;
      res_q         <= '0;
      c_rsp_valid_q <= 1'b0;
      k_rsp_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      op_q          <= op_d;
      res_q         <= res_d;
      c_rsp_valid_q <= c_rsp_valid_d;
      k_rsp_valid_q <= k_rsp_valid_d;
    end
  end

  assign c_req_ready = c_grant;
  assign k_req_ready = k_grant;
  assign c_rsp_valid = c_rsp_valid_q;
  assign k_rsp_valid = k_rsp_valid_q;
  // Data is gated by valid so a key result's upper bits never leak out.
  assign c_rsp_data  = c_rsp_valid_q ? res_q : '0;
  assign k_rsp_data  = k_rsp_valid_q ? res_q[WORD_W-1:0] : '0;
  assign busy        = (state_q != IDLE);

`ifdef SBOX_ARB_STATS_EN
  logic [15:0] c_grant_cnt_q, c_grant_cnt_d;
  logic [15:0] k_grant_cnt_q, k_grant_cnt_d;
  logic [7:0]  c_wait_run_q, c_wait_run_d;
  logic [7:0]  c_wait_max_q, c_wait_max_d;

  // c_wait_run tracks the current unbroken stretch of an unserved cipher
  // request; c_wait_max keeps the longest one seen.
  always_comb begin
    c_grant_cnt_d = c_grant_cnt_q;
    k_grant_cnt_d = k_grant_cnt_q;
    c_wait_run_d  = 8'd0;
    c_wait_max_d  = c_wait_max_q;
    if (c_grant) c_grant_cnt_d = c_grant_cnt_q + 16'd1;
    if (k_grant) k_grant_cnt_d = k_grant_cnt_q + 16'd1;
    if (c_req_valid && !c_grant) begin
      c_wait_run_d = (c_wait_run_q == 8'hFF) ? 8'hFF : c_wait_run_q + 8'd1;
    end
    if (c_wait_run_d > c_wait_max_q) c_wait_max_d = c_wait_run_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_grant_cnt_q <= '0;
      k_grant_cnt_q <= '0;
      c_wait_run_q  <= '0;
      c_wait_max_q  <= '0;
    end else begin
      c_grant_cnt_q <= c_grant_cnt_d;
      k_grant_cnt_q <= k_grant_cnt_d;
      c_wait_run_q  <= c_wait_run_d;
      c_wait_max_q  <= c_wait_max_d;
    end
  end

  assign c_grant_cnt = c_grant_cnt_q;
  assign k_grant_cnt = k_grant_cnt_q;
  assign c_wait_max  = c_wait_max_q;
`endif

endmodule

// File: tb/tb_sbox_arbiter.sv
// Self-checking bench for sbox_arbiter. Expected results come from an
// arithmetic S-box model (GF(2^8) inverse plus affine map); they are queued
// at each request handshake and compared at each response handshake.
module tb_sbox_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  logic         c_req_valid, c_req_ready, c_rsp_valid, c_rsp_ready;
  logic [127:0] c_req_data, c_rsp_data;
  logic         k_req_valid, k_req_ready, k_rsp_valid, k_rsp_ready;
  logic [31:0]  k_req_data, k_rsp_data;
  logic         busy;

  logic         fp_c_req_valid, fp_c_req_ready, fp_c_rsp_valid, fp_c_rsp_ready;
  logic [127:0] fp_c_req_data, fp_c_rsp_data;
  logic         fp_k_req_valid, fp_k_req_ready, fp_k_rsp_valid, fp_k_rsp_ready;
  logic [31:0]  fp_k_req_data, fp_k_rsp_data;
  logic         fp_busy;

`ifdef SBOX_ARB_STATS_EN
  logic [15:0] c_grant_cnt, k_grant_cnt, fp_c_grant_cnt, fp_k_grant_cnt;
  logic [7:0]  c_wait_max, fp_c_wait_max;
`endif

  int checks = 0;
  int errors = 0;

  logic [127:0] cExp[$];
  logic [127:0] kExp[$];
  bit           grantLog[$];
  int           cGrants = 0;
  int           kGrants = 0;
  int           waitRun = 0;
  int           waitMax = 0;
  int           fpCGrants = 0;
  int           fpKGrants = 0;

  // 10 ns clock.
  always #5 clk = ~clk;

  sbox_arbiter #(.FIXED_PRIO(0), .WORD_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_data(c_req_data),
    .c_rsp_valid(c_rsp_valid), .c_rsp_ready(c_rsp_ready), .c_rsp_data(c_rsp_data),
    .k_req_valid(k_req_valid), .k_req_ready(k_req_ready), .k_req_data(k_req_data),
    .k_rsp_valid(k_rsp_valid), .k_rsp_ready(k_rsp_ready), .k_rsp_data(k_rsp_data),
    .busy(busy)
`ifdef SBOX_ARB_STATS_EN
    , .c_grant_cnt(c_grant_cnt), .k_grant_cnt(k_grant_cnt), .c_wait_max(c_wait_max)
`endif
  );

  sbox_arbiter #(.FIXED_PRIO(1), .WORD_W(32)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .c_req_valid(fp_c_req_valid), .c_req_ready(fp_c_req_ready), .c_req_data(fp_c_req_data),
    .c_rsp_valid(fp_c_rsp_valid), .c_rsp_ready(fp_c_rsp_ready), .c_rsp_data(fp_c_rsp_data),
    .k_req_valid(fp_k_req_valid), .k_req_ready(fp_k_req_ready), .k_req_data(fp_k_req_data),
    .k_rsp_valid(fp_k_rsp_valid), .k_rsp_ready(fp_k_rsp_ready), .k_rsp_data(fp_k_rsp_data),
    .busy(fp_busy)
`ifdef SBOX_ARB_STATS_EN
    , .c_grant_cnt(fp_c_grant_cnt), .k_grant_cnt(fp_k_grant_cnt), .c_wait_max(fp_c_wait_max)
`endif
  );

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // Multiplicative inverse as b^254 (0 maps to 0), then the AES affine map.
  function automatic logic [7:0] refSbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gfMul(inv, b);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] refSub(input logic [127:0] v);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = refSbox(v[i*8 +: 8]);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Raises valid on one requester, waits (bounded) for ready, then drops it
  // right after the accepting edge.
  task automatic applyStimulus(input bit isKey, input logic [127:0] data);
    bit accepted;
    accepted = 1'b0;
    @(posedge clk);
    #1;
    if (isKey) begin k_req_valid = 1'b1; k_req_data = data[31:0]; end
    else       begin c_req_valid = 1'b1; c_req_data = data; end
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (isKey ? k_req_ready : c_req_ready) accepted = 1'b1;
    end
    checkOutput(isKey ? "kReqAccept" : "cReqAccept", accepted, 1);
    @(posedge clk);
    #1;
    if (isKey) k_req_valid = 1'b0;
    else       c_req_valid = 1'b0;
  endtask

  // Counts edges from the caller's point until the response becomes valid.
  task automatic waitRsp(input bit isKey, output logic [127:0] data, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    data = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (isKey ? k_rsp_valid : c_rsp_valid) begin
        got = 1'b1;
        data = isKey ? {96'b0, k_rsp_data} : c_rsp_data;
      end
    end
    checkOutput("rspArrived", got, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (cExp.size() == 0 && kExp.size() == 0 && !busy) done = 1'b1;
    end
    checkOutput("drain", done, 1);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard: push the model result at request handshakes, pop and compare
  // at response handshakes, and watch exclusivity and spurious valids.
  always @(negedge clk) begin
    logic [127:0] e;
    if (!rst_n) begin
      cExp.delete();
      kExp.delete();
      cGrants = 0;
      kGrants = 0;
      waitRun = 0;
      waitMax = 0;
    end else begin
      if (c_req_valid && c_req_ready) begin
        cExp.push_back(refSub(c_req_data));
        grantLog.push_back(1'b0);
        cGrants++;
      end
      if (k_req_valid && k_req_ready) begin
        kExp.push_back(refSub({96'b0, k_req_data}));
        grantLog.push_back(1'b1);
        kGrants++;
      end
      checkOutput("readyExclusive", c_req_ready & k_req_ready, 0);
      if (cExp.size() == 0) checkOutput("cRspSpurious", c_rsp_valid, 0);
      else if (c_rsp_valid && c_rsp_ready) begin
        e = cExp.pop_front();
        checkOutput("cRsp", c_rsp_data, e);
      end
      if (kExp.size() == 0) checkOutput("kRspSpurious", k_rsp_valid, 0);
      else if (k_rsp_valid && k_rsp_ready) begin
        e = kExp.pop_front();
        checkOutput("kRsp", {96'b0, k_rsp_data}, {96'b0, e[31:0]});
      end
      if (c_req_valid && !c_req_ready) waitRun = (waitRun == 255) ? 255 : waitRun + 1;
      else                             waitRun = 0;
      if (waitRun > waitMax) waitMax = waitRun;
    end
  end

  // Grant tally and data check for the fixed-priority instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fp_c_req_valid && fp_c_req_ready) fpCGrants++;
      if (fp_k_req_valid && fp_k_req_ready) fpKGrants++;
      if (fp_c_rsp_valid) checkOutput("fpCRsp", fp_c_rsp_data, refSub(fp_c_req_data));
    end
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] d;
    int lat, busyCnt;
    logic [127:0] bpExp;

    rst_n = 1'b1;
    c_req_valid = 0; c_req_data = '0; c_rsp_ready = 0;
    k_req_valid = 0; k_req_data = '0; k_rsp_ready = 0;
    fp_c_req_valid = 0; fp_c_req_data = 128'h00112233445566778899aabbccddeeff;
    fp_k_req_valid = 0; fp_k_req_data = 32'hdeadbeef;
    fp_c_rsp_ready = 1; fp_k_rsp_ready = 1;

    // Reset state.
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstCRspValid", c_rsp_valid, 0);
    checkOutput("rstKRspValid", k_rsp_valid, 0);
    checkOutput("rstCRspData", c_rsp_data, 0);
    checkOutput("rstKRspData", k_rsp_data, 0);
    checkOutput("rstReady", {c_req_ready, k_req_ready}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Cipher only, all-zero state.
    c_rsp_ready = 1; k_rsp_ready = 1;
    applyStimulus(1'b0, 128'h0);
    waitRsp(1'b0, d, lat);
    checkOutput("cLatency", lat, 2);
    checkOutput("cZeroData", d, {16{8'h63}});
    drain();

    // Key only; busy spans exactly three cycles.
    applyStimulus(1'b1, 128'hCF4F3C09);
    busyCnt = 0;
    d = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (k_rsp_valid) d = {96'b0, k_rsp_data};
    end
    checkOutput("kBusyCycles", busyCnt, 3);
    checkOutput("kWordData", d, 128'h8A84EB01);
    drain();

    // Simultaneous requests after reset alternate C,K,C,K.
    doReset();
    grantLog.delete();
    for (int r = 0; r < 2; r++) begin
      fork
        applyStimulus(1'b0, {$urandom, $urandom, $urandom, $urandom});
        applyStimulus(1'b1, {96'b0, $urandom});
      join
      drain();
    end
    checkOutput("rrCount", grantLog.size(), 4);
    for (int i = 0; i < 4 && i < grantLog.size(); i++)
      checkOutput($sformatf("rrOrder%0d", i), grantLog[i], (i % 2 == 1));

    // After a lone cipher grant, a tie goes to the key.
    grantLog.delete();
    applyStimulus(1'b0, {$urandom, $urandom, $urandom, $urandom});
    drain();
    fork
      applyStimulus(1'b0, {$urandom, $urandom, $urandom, $urandom});
      applyStimulus(1'b1, {96'b0, $urandom});
    join
    drain();
    checkOutput("rrKeyCount", grantLog.size(), 3);
    if (grantLog.size() == 3) begin
      checkOutput("rrKeyFirst", grantLog[1], 1);
      checkOutput("rrCipherLast", grantLog[2], 0);
    end

    // Backpressure: result held while the key request waits.
    c_rsp_ready = 0;
    bpExp = {{15{8'h7C}}, 8'hED};
    applyStimulus(1'b0, {{15{8'h01}}, 8'h53});
    fork
      applyStimulus(1'b1, 128'h01234567);
      begin
        waitRsp(1'b0, d, lat);
        checkOutput("bpFirst", d, bpExp);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checkOutput("bpHoldData", c_rsp_data, bpExp);
          checkOutput("bpHoldValid", c_rsp_valid, 1);
          checkOutput("bpKeyBlocked", k_req_ready, 0);
        end
        @(posedge clk);
        #1 c_rsp_ready = 1;
      end
    join
    drain();

    // Reset during LOOKUP discards the operation; the reissue completes.
    applyStimulus(1'b1, 128'hFFFFFFFF);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstValids", {c_rsp_valid, k_rsp_valid}, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 128'hFFFFFFFF);
    waitRsp(1'b1, d, lat);
    checkOutput("reissueLatency", lat, 2);
    checkOutput("reissueData", d, 128'h16161616);
    drain();

    // Fixed-priority instance: a permanent tie is always won by the cipher.
    @(posedge clk);
    #1;
    fp_c_req_valid = 1; fp_k_req_valid = 1;
    repeat (30) @(posedge clk);
    #1;
    fp_c_req_valid = 0; fp_k_req_valid = 0;
    repeat (6) @(posedge clk);
    checkOutput("fpKeyGrants", fpKGrants, 0);
    checkOutput("fpCipherGrants", (fpCGrants >= 5), 1);

    // Grant statistics: 3 cipher plus 2 key operations after reset.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, {$urandom, $urandom, $urandom, $urandom});
      drain();
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, {96'b0, $urandom});
      drain();
    end
    checkOutput("tallyC", cGrants, 3);
    checkOutput("tallyK", kGrants, 2);
`ifdef SBOX_ARB_STATS_EN
    checkOutput("cGrantCnt", c_grant_cnt, 3);
    checkOutput("kGrantCnt", k_grant_cnt, 2);
    checkOutput("cWaitMax", c_wait_max, waitMax);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
